// File: rtl/pwm_enable_sequencer.sv
// pwm_enable_sequencer
//   Ramps N_CHAINS PWM generator chains up one at a time (ascending index)
//   and back down (descending index) from a single global enable, waiting a
//   programmable number of cycles before each step. A fault kills every chain
//   at the next edge and holds them off until it is acknowledged.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   enable            global run request (level)
//   fault             fault request (level), overrides everything but reset
//   clear_fault       fault acknowledge; honoured only with enable=0, fault=0
//   step_delay        packed per-chain delays, chain i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//   chain_enable      registered per-chain enables (always a thermometer code)
//   sequence_busy     ramping up or down
//   all_running       every chain on, sequence complete
//   fault_latched     held in fault
module pwm_enable_sequencer #(
  parameter int N_CHAINS      = 4,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                fault,
  input  logic                                clear_fault,
  input  logic [N_CHAINS*COUNTER_WIDTH-1:0]   step_delay,
  output logic [N_CHAINS-1:0]                 chain_enable,
  output logic                                sequence_busy,
  output logic                                all_running,
  output logic                                fault_latched
);

  localparam int IW = (N_CHAINS > 1) ? $clog2(N_CHAINS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_CHAINS - 1);

  typedef enum logic [2:0] {IDLE, STARTING, RUNNING, STOPPING, FAULT} state_t;

  state_t                                  state, state_n;
  logic [IW-1:0]                           idx, idx_n;
  logic [COUNTER_WIDTH-1:0]                cnt, cnt_n;
  logic [N_CHAINS-1:0]                     ce_n;
  logic [N_CHAINS-1:0][COUNTER_WIDTH-1:0]  lat;
  logic                                    load;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    ce_n    = chain_enable;
    load    = 1'b0;
    if (fault) begin
      state_n = FAULT;
      ce_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            // Delays are snapshotted here only; later step_delay edits wait
            // for the next start.
            load    = 1'b1;
            idx_n   = '0;
            cnt_n   = step_delay[0 +: COUNTER_WIDTH];
            state_n = STARTING;
          end
        end
        STARTING: begin
          if (!enable) begin
            // idx points at the next chain to enable, so idx-1 is the
            // highest chain already on.
            if (idx == '0 && !chain_enable[0]) begin
              ce_n    = '0;
              state_n = IDLE;
            end else begin
              idx_n   = idx - 1'b1;
              cnt_n   = lat[idx_n];
              state_n = STOPPING;
            end
          end else if (cnt == '0) begin
            ce_n[idx] = 1'b1;
            if (idx == LAST) begin
              state_n = RUNNING;
            end else begin
              idx_n = idx + 1'b1;
              cnt_n = lat[idx_n];
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        RUNNING: begin
          ce_n = '1;
          if (!enable) begin
            idx_n   = LAST;
            cnt_n   = lat[LAST];
            state_n = STOPPING;
          end
        end
        STOPPING: begin
          // enable is deliberately ignored: a stop always runs to IDLE.
          if (cnt == '0) begin
            ce_n[idx] = 1'b0;
            if (idx == '0) begin
              state_n = IDLE;
            end else begin
              idx_n = idx - 1'b1;
              cnt_n = lat[idx_n];
            end
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        FAULT: begin
          ce_n = '0;
          if (clear_fault && !enable) state_n = IDLE;
        end
        default: begin
          ce_n    = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      lat           <= '0;
      chain_enable  <= '0;
      sequence_busy <= 1'b0;
      all_running   <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      cnt           <= cnt_n;
      chain_enable  <= ce_n;
      if (load) lat <= step_delay;
      // Status flags decoded from next state so they align with chain_enable.
      sequence_busy <= (state_n == STARTING) || (state_n == STOPPING);
      all_running   <= (state_n == RUNNING);
      fault_latched <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_pwm_enable_sequencer.sv
module tb_pwm_enable_sequencer;
  localparam int N  = 4;
  localparam int CW = 16;

  logic              clock = 1'b0;
  logic              reset, enable, fault, clear_fault;
  logic [N*CW-1:0]   step_delay;
  logic [N-1:0]      chain_enable;
  logic              sequence_busy, all_running, fault_latched;

  pwm_enable_sequencer #(.N_CHAINS(N), .COUNTER_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .fault(fault),
    .clear_fault(clear_fault), .step_delay(step_delay),
    .chain_enable(chain_enable), .sequence_busy(sequence_busy),
    .all_running(all_running), .fault_latched(fault_latched)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit armed  = 1'b0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: the chains form a thermometer, so track only how many
  // are on, the phase we are in and the remaining wait before the next step.
  localparam int M_IDLE = 0, M_UP = 1, M_FULL = 2, M_DOWN = 3, M_FLT = 4;
  int m_mode = M_IDLE, m_on = 0, m_wait = 0;
  int m_d [N];

  function automatic int dly(input logic [N*CW-1:0] v, input int i);
    return int'(v[i*CW +: CW]);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_mode = M_IDLE; m_on = 0; m_wait = 0;
      for (int i = 0; i < N; i++) m_d[i] = 0;
    end else if (fault) begin
      m_mode = M_FLT; m_on = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (enable) begin
          for (int i = 0; i < N; i++) m_d[i] = dly(step_delay, i);
          m_mode = M_UP; m_wait = m_d[0];
        end
        M_UP: begin
          if (!enable) begin
            if (m_on == 0) m_mode = M_IDLE;
            else begin m_mode = M_DOWN; m_wait = m_d[m_on-1]; end
          end else if (m_wait == 0) begin
            m_on++;
            if (m_on == N) m_mode = M_FULL;
            else m_wait = m_d[m_on];
          end else m_wait--;
        end
        M_FULL: if (!enable) begin m_mode = M_DOWN; m_wait = m_d[N-1]; end
        M_DOWN: begin
          if (m_wait == 0) begin
            m_on--;
            if (m_on == 0) m_mode = M_IDLE;
            else m_wait = m_d[m_on-1];
          end else m_wait--;
        end
        default: if (clear_fault && !enable) m_mode = M_IDLE;
      endcase
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    model_step();
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (armed) begin
      logic [N-1:0] e_ce;
      e_ce = N'((1 << m_on) - 1);
      check("outputs{ce,busy,run,flt}",
            int'({chain_enable, sequence_busy, all_running, fault_latched}),
            int'({e_ce, (m_mode == M_UP || m_mode == M_DOWN),
                  (m_mode == M_FULL), (m_mode == M_FLT)}));
    end
  end

  // Edge at which each chain last rose / fell.
  int rise_at [N];
  int fall_at [N];
  logic [N-1:0] prev_ce = '0;
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (chain_enable[i] === 1'b1 && prev_ce[i] !== 1'b1) rise_at[i] = cyc;
      if (chain_enable[i] === 1'b0 && prev_ce[i] === 1'b1) fall_at[i] = cyc;
    end
    prev_ce = chain_enable;
  end

  task automatic clr_marks();
    for (int i = 0; i < N; i++) begin rise_at[i] = -1; fall_at[i] = -1; end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  function automatic logic [N*CW-1:0] pack(input int a, input int b, input int c, input int d);
    return {CW'(d), CW'(c), CW'(b), CW'(a)};
  endfunction

  int k, m;

  initial begin
    reset = 1'b1; enable = 1'b0; fault = 1'b0; clear_fault = 1'b0;
    step_delay = '0;
    clr_marks();
    tick(1);
    armed = 1'b1;
    tick(1);
    reset = 1'b0;
    check("reset_ce", int'(chain_enable), 0);
    check("reset_status", int'({sequence_busy, all_running, fault_latched}), 0);

    // Zero delays: chains at consecutive edges.
    clr_marks();
    enable = 1'b1; k = cyc + 1;
    tick(6);
    for (int i = 0; i < N; i++) check($sformatf("d0_rise%0d", i), rise_at[i] - k, 1 + i);
    check("d0_all_running", int'(all_running), 1);
    enable = 1'b0; m = cyc + 1;
    tick(6);
    for (int i = 0; i < N; i++) check($sformatf("d0_fall%0d", i), fall_at[i] - m, N - i);

    // Delays {2,3,0,1}.
    clr_marks();
    step_delay = pack(2, 3, 0, 1);
    enable = 1'b1; k = cyc + 1;
    tick(12);
    check("mix_rise0", rise_at[0] - k, 3);
    check("mix_rise1", rise_at[1] - k, 7);
    check("mix_rise2", rise_at[2] - k, 8);
    check("mix_rise3", rise_at[3] - k, 10);
    enable = 1'b0; m = cyc + 1;
    tick(12);
    check("mix_fall3", fall_at[3] - m, 2);
    check("mix_fall2", fall_at[2] - m, 3);
    check("mix_fall1", fall_at[1] - m, 7);
    check("mix_fall0", fall_at[0] - m, 10);
    check("mix_idle_busy", int'(sequence_busy), 0);

    // Abort during start with delays 5.
    clr_marks();
    step_delay = pack(5, 5, 5, 5);
    enable = 1'b1; k = cyc + 1;
    tick(14);
    check("abort_rise1", rise_at[1] - k, 12);
    enable = 1'b0;                       // sampled at edge k+14
    tick(20);
    check("abort_no_rise2", rise_at[2], -1);
    check("abort_fall1", fall_at[1] - k, 20);
    check("abort_fall0", fall_at[0] - k, 26);
    check("abort_idle", int'({sequence_busy, all_running, chain_enable}), 0);

    // Delay edit mid-start is ignored; then reset mid-stop.
    clr_marks();
    step_delay = pack(3, 3, 3, 3);
    enable = 1'b1; k = cyc + 1;
    tick(2);
    step_delay = pack(10, 10, 10, 10);
    tick(16);
    for (int i = 0; i < N; i++) check($sformatf("latch_rise%0d", i), rise_at[i] - k, 1 + i + 3 * (i + 1));
    enable = 1'b0;
    tick(3);
    check("stopping_busy", int'(sequence_busy), 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midstop_reset", int'({chain_enable, sequence_busy, all_running, fault_latched}), 0);

    // Fault handling.
    step_delay = '0;
    enable = 1'b1;
    tick(6);
    check("pre_fault_run", int'(all_running), 1);
    fault = 1'b1; tick(1); fault = 1'b0;
    check("fault_ce", int'(chain_enable), 0);
    check("fault_latched", int'(fault_latched), 1);
    clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    check("clear_with_enable", int'(fault_latched), 1);
    enable = 1'b0; clear_fault = 1'b1; tick(1); clear_fault = 1'b0;
    check("clear_to_idle", int'({fault_latched, sequence_busy, chain_enable}), 0);

    // Maximum delay: counter must hold off without wrapping.
    step_delay = pack(65535, 0, 0, 0);
    enable = 1'b1;
    tick(40);
    check("maxdly_hold", int'({chain_enable, sequence_busy}), 1);
    enable = 1'b0;
    tick(1);
    check("maxdly_abort", int'({chain_enable, sequence_busy}), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      fault       = ($urandom_range(0, 79) == 0);
      clear_fault = ($urandom_range(0, 3) == 0);
      reset       = ($urandom_range(0, 699) == 0);
      for (int i = 0; i < N; i++) step_delay[i*CW +: CW] = CW'($urandom_range(0, 4));
      tick(1);
    end

    reset = 1'b0; enable = 1'b0; fault = 1'b0; clear_fault = 1'b0;
    tick(2);
    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
